// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared widths, FSM/port typedefs and helpers for mem_arbiter.
package mem_arb_pkg;

   localparam int unsigned ADDR_W = 28;
   localparam int unsigned DATA_W = 128;
   localparam int unsigned PERF_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2
   } arb_state_e;

   typedef enum logic {
      PORT_I = 1'b0,
      PORT_D = 1'b1
   } port_e;

   // One requester's view of the memory bus
   typedef struct packed {
      logic              read;
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_req_t;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
      return (v == {PERF_W{1'b1}}) ? v : v + PERF_W'(1);
   endfunction

endpackage

// File: rtl/mem_arb_perf.sv
// mem_arb_perf: saturating grant/wait counters for mem_arbiter.
// Only present when MEM_ARB_PERF_EN is defined.
`ifdef MEM_ARB_PERF_EN
module mem_arb_perf
   import mem_arb_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              grant_i,
   input  logic              grant_d,
   input  logic              wait_pend,
   output logic [PERF_W-1:0] i_grants,
   output logic [PERF_W-1:0] d_grants,
   output logic [PERF_W-1:0] wait_cnt
);

   // Count grant entries and waiting cycles, holding at full scale
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_grants <= '0;
         d_grants <= '0;
         wait_cnt <= '0;
      end else begin
         if (grant_i)   i_grants <= sat_inc(i_grants);
         if (grant_d)   d_grants <= sat_inc(d_grants);
         if (wait_pend) wait_cnt <= sat_inc(wait_cnt);
      end
   end

endmodule
`endif

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one 128-bit-line memory between
// the I-cache (port 0) and D-cache (port 1). Grants are registered and held
// until mem_ready. Define MEM_ARB_PERF_EN to build the performance counters;
// otherwise the perf ports read 0.
module mem_arbiter
   import mem_arb_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_read,
   input  logic              i_write,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ready,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [PERF_W-1:0] perf_i_grants,
   output logic [PERF_W-1:0] perf_d_grants,
   output logic [PERF_W-1:0] perf_wait
);

   arb_state_e state, state_next;
   port_e      last_gnt, last_gnt_next;
   logic       req_i, req_d;
   mem_req_t   port_i, port_d, mem_req;

   assign req_i  = i_read | i_write;
   assign req_d  = d_read | d_write;
   assign port_i = '{read: i_read, write: i_write, addr: i_addr, wdata: i_wdata};
   assign port_d = '{read: d_read, write: d_write, addr: d_addr, wdata: d_wdata};

   // Grant state and round-robin history
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         last_gnt <= PORT_D;
      end else begin
         state    <= state_next;
         last_gnt <= last_gnt_next;
      end
   end

   // Next grant: ties go to the port not served last; release on mem_ready
   always_comb begin
      state_next    = state;
      last_gnt_next = last_gnt;
      case (state)
         IDLE: begin
            if (req_i && req_d) begin
               state_next = (last_gnt == PORT_I) ? GNT_D : GNT_I;
            end else if (req_i) begin
               state_next = GNT_I;
            end else if (req_d) begin
               state_next = GNT_D;
            end
         end
         GNT_I: begin
            if (mem_ready) begin
               state_next    = IDLE;
               last_gnt_next = PORT_I;
            end
         end
         GNT_D: begin
            if (mem_ready) begin
               state_next    = IDLE;
               last_gnt_next = PORT_D;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Route the granted port to memory and mem_ready back to it only
   always_comb begin
      mem_req = '0;
      i_ready = 1'b0;
      d_ready = 1'b0;
      case (state)
         GNT_I: begin
            mem_req = port_i;
            i_ready = mem_ready;
         end
         GNT_D: begin
            mem_req = port_d;
            d_ready = mem_ready;
         end
         default: ;
      endcase
   end

   assign mem_read  = mem_req.read;
   assign mem_write = mem_req.write;
   assign mem_addr  = mem_req.addr;
   assign mem_wdata = mem_req.wdata;
   assign i_rdata   = mem_rdata;
   assign d_rdata   = mem_rdata;

`ifdef MEM_ARB_PERF_EN
   logic wait_pend;

   // A port waits when it requests but neither holds nor is taking the grant
   assign wait_pend = (req_i && state != GNT_I && state_next != GNT_I) ||
                      (req_d && state != GNT_D && state_next != GNT_D);

   mem_arb_perf u_perf (
      .clk       (clk),
      .rst_n     (rst_n),
      .grant_i   (state == IDLE && state_next == GNT_I),
      .grant_d   (state == IDLE && state_next == GNT_D),
      .wait_pend (wait_pend),
      .i_grants  (perf_i_grants),
      .d_grants  (perf_d_grants),
      .wait_cnt  (perf_wait)
   );
`else
   assign perf_i_grants = '0;
   assign perf_d_grants = '0;
   assign perf_wait     = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized self-checking bench for mem_arbiter with a
// behavioural memory (mem[a] = a at start) and a shadow copy for data checks.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              i_read, i_write, d_read, d_write;
   logic [ADDR_W-1:0] i_addr, d_addr, mem_addr;
   logic [DATA_W-1:0] i_wdata, d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
   logic              i_ready, d_ready, mem_read, mem_write, mem_ready;
   logic [PERF_W-1:0] perf_i_grants, perf_d_grants, perf_wait;

   int assertions = 0;
   int failures   = 0;
   int cyc        = 0;
   int lat_mode   = 1;
   logic [DATA_W-1:0] mem_arr [256];
   logic [DATA_W-1:0] shadow  [256];
   int rdy_log [$];

   mem_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
      .i_rdata(i_rdata), .i_ready(i_ready),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants), .perf_wait(perf_wait)
   );

   initial forever #5 clk = ~clk;
   initial forever begin @(posedge clk); cyc++; end

   // Memory: answers after lat extra cycles with a one-cycle mem_ready pulse
   initial begin
      int mcnt;
      int cur_lat;
      bit busy;
      mcnt = 0; cur_lat = 0; busy = 1'b0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk); #2;
         if (!rst_n || mem_ready) begin
            mem_ready = 1'b0; mcnt = 0; busy = 1'b0;
         end else if (mem_read || mem_write) begin
            if (!busy) begin
               busy = 1'b1; mcnt = 0;
               cur_lat = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
            end
            if (mcnt >= cur_lat) begin
               if (mem_write) mem_arr[mem_addr[7:0]] = mem_wdata;
               mem_rdata = mem_arr[mem_addr[7:0]];
               mem_ready = 1'b1;
            end else begin
               mcnt++;
            end
         end else begin
            mcnt = 0; busy = 1'b0;
         end
      end
   end

   // Readies are never both high; log which port completed
   initial forever begin
      @(negedge clk);
      if (i_ready || d_ready) begin
         assertions++;
         if (i_ready && d_ready) begin
            failures++;
            $display("FAIL ready_exclusive: i_ready=%b d_ready=%b at cycle %0d, required one-hot", i_ready, d_ready, cyc);
         end
         rdy_log.push_back(i_ready ? 0 : 1);
      end
   end

   task automatic sync();
      @(posedge clk); #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      i_read = 0; i_write = 0; d_read = 0; d_write = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Port 0 requester: hold request until ready, report data and model value
   task automatic req_i(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                        output logic [DATA_W-1:0] rd, output logic [DATA_W-1:0] ex, output int done);
      int n = 0;
      i_read = ~wr; i_write = wr; i_addr = a; i_wdata = wd;
      do begin @(negedge clk); n++; end while (!i_ready && n < 64);
      assertions++;
      if (!i_ready) begin
         failures++;
         $display("FAIL i_timeout: no i_ready for addr %h within 64 cycles", a);
      end
      rd = i_rdata; ex = shadow[a[7:0]]; done = cyc;
      if (wr) shadow[a[7:0]] = wd;
      @(posedge clk); #1;
      i_read = 0; i_write = 0;
   endtask

   // Port 1 requester
   task automatic req_d(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                        output logic [DATA_W-1:0] rd, output logic [DATA_W-1:0] ex, output int done);
      int n = 0;
      d_read = ~wr; d_write = wr; d_addr = a; d_wdata = wd;
      do begin @(negedge clk); n++; end while (!d_ready && n < 64);
      assertions++;
      if (!d_ready) begin
         failures++;
         $display("FAIL d_timeout: no d_ready for addr %h within 64 cycles", a);
      end
      rd = d_rdata; ex = shadow[a[7:0]]; done = cyc;
      if (wr) shadow[a[7:0]] = wd;
      @(posedge clk); #1;
      d_read = 0; d_write = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      i_read = 1; i_write = 0; i_addr = 28'h5; i_wdata = '1;
      d_read = 0; d_write = 1; d_addr = 28'h6; d_wdata = '1;
      repeat (3) @(negedge clk);
      assertions++;
      if ({mem_read, mem_write} !== 2'b00) begin
         failures++; $display("FAIL reset_strobes: got %b, required 00", {mem_read, mem_write});
      end
      assertions++;
      if (mem_addr !== '0 || mem_wdata !== '0) begin
         failures++; $display("FAIL reset_bus: addr=%h wdata=%h, required 0", mem_addr, mem_wdata);
      end
      assertions++;
      if ({i_ready, d_ready} !== 2'b00) begin
         failures++; $display("FAIL reset_ready: got %b, required 00", {i_ready, d_ready});
      end
      assertions++;
      if (perf_i_grants !== 0 || perf_d_grants !== 0 || perf_wait !== 0) begin
         failures++; $display("FAIL reset_perf: %0d %0d %0d, required 0 0 0", perf_i_grants, perf_d_grants, perf_wait);
      end
      i_read = 0; d_write = 0;
      sync();
      rst_n = 1'b1;
      sync();
   endtask

   task automatic test_solo_read();
      logic [DATA_W-1:0] rd, ex;
      int done;
      lat_mode = 1;
      fork
         req_i(1'b0, 28'h10, '0, rd, ex, done);
         begin
            int n = 0;
            @(negedge clk);
            assertions++;
            if (mem_read !== 1'b0) begin
               failures++; $display("FAIL solo_no_early_grant: mem_read=%b, required 0", mem_read);
            end
            @(negedge clk);
            assertions++;
            if (mem_read !== 1'b1 || mem_addr !== 28'h10) begin
               failures++; $display("FAIL solo_grant: mem_read=%b addr=%h, required 1 / 10", mem_read, mem_addr);
            end
            while (!i_ready && n < 64) begin @(negedge clk); n++; end
            assertions++;
            if (d_ready !== 1'b0 || d_rdata !== 128'h10) begin
               failures++; $display("FAIL solo_d_side: d_ready=%b d_rdata=%h, required 0 / 10", d_ready, d_rdata);
            end
            @(negedge clk);
            assertions++;
            if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== '0) begin
               failures++; $display("FAIL solo_release: read=%b write=%b addr=%h, required 0", mem_read, mem_write, mem_addr);
            end
         end
      join
      assertions++;
      if (rd !== 128'h10) begin
         failures++; $display("FAIL solo_rdata: got %h, required 10", rd);
      end
   endtask

   task automatic test_tie();
      logic [DATA_W-1:0] rdi, exi, rdd, exd, wd;
      int di, dd;
      wd = {$urandom, $urandom, $urandom, $urandom};
      apply_reset();
      lat_mode = 1;
      fork
         req_i(1'b0, 28'h20, '0, rdi, exi, di);
         req_d(1'b1, 28'h30, wd, rdd, exd, dd);
         begin
            int n = 0;
            @(negedge clk); @(negedge clk);
            assertions++;
            if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 28'h20) begin
               failures++; $display("FAIL tie_first_grant: read=%b write=%b addr=%h, required I read of 20", mem_read, mem_write, mem_addr);
            end
            while (!i_ready && n < 64) begin @(negedge clk); n++; end
            @(negedge clk);
            assertions++;
            if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
               failures++; $display("FAIL tie_idle_gap: read=%b write=%b, required idle", mem_read, mem_write);
            end
            @(negedge clk);
            assertions++;
            if (mem_write !== 1'b1 || mem_addr !== 28'h30 || mem_wdata !== wd) begin
               failures++; $display("FAIL tie_d_write: write=%b addr=%h, required 1 / 30", mem_write, mem_addr);
            end
         end
      join
      assertions++;
      if (rdi !== exi || rdi !== 128'h20) begin
         failures++; $display("FAIL tie_i_rdata: got %h, required 20", rdi);
      end
      assertions++;
      if (!(di < dd)) begin
         failures++; $display("FAIL tie_order: I done %0d, D done %0d, required I first", di, dd);
      end
      assertions++;
      if (mem_arr[8'h30] !== wd) begin
         failures++; $display("FAIL tie_mem_line: got %h, required %h", mem_arr[8'h30], wd);
      end
   endtask

   task automatic test_stream();
      logic [DATA_W-1:0] rd, ex;
      int done_i, raise_i;
      int exp_log [$];
      lat_mode = 2;
      exp_log = {1, 0, 1, 1};
      rdy_log.delete();
      fork
         begin
            int dd;
            logic [DATA_W-1:0] r2, e2;
            for (int k = 0; k < 3; k++) begin
               req_d(1'b0, ADDR_W'(8'h50 + k), '0, r2, e2, dd);
               assertions++;
               if (r2 !== e2) begin
                  failures++; $display("FAIL stream_d_rdata: got %h, required %h", r2, e2);
               end
            end
         end
         begin
            sync(); sync();
            raise_i = cyc;
            req_i(1'b0, 28'h60, '0, rd, ex, done_i);
         end
      join
      assertions++;
      if (rdy_log != exp_log) begin
         failures++; $display("FAIL stream_order: got %p, required %p", rdy_log, exp_log);
      end
      assertions++;
      if (done_i - raise_i > 2 * lat_mode + 2) begin
         failures++; $display("FAIL stream_i_wait: I took %0d cycles, required <= %0d", done_i - raise_i, 2 * lat_mode + 2);
      end
      assertions++;
      if (rd !== 128'h60) begin
         failures++; $display("FAIL stream_i_rdata: got %h, required 60", rd);
      end
   endtask

   task automatic test_reset_mid();
      logic [DATA_W-1:0] rd, ex, rd2, ex2;
      int done, n;
      apply_reset();
      lat_mode = 1;
      req_i(1'b0, 28'h11, '0, rd, ex, done);
      lat_mode = 6;
      d_write = 1'b1; d_addr = 28'h40; d_wdata = {$urandom, $urandom, $urandom, $urandom};
      n = 0;
      while (!mem_write && n < 64) begin @(negedge clk); n++; end
      assertions++;
      if (mem_write !== 1'b1) begin
         failures++; $display("FAIL rstmid_grant: mem_write=%b, required 1 before reset", mem_write);
      end
      rst_n = 1'b0;
      #1;
      assertions++;
      if (mem_write !== 1'b0 || mem_read !== 1'b0 || mem_addr !== '0 || d_ready !== 1'b0) begin
         failures++; $display("FAIL rstmid_drop: write=%b read=%b addr=%h, required 0", mem_write, mem_read, mem_addr);
      end
      d_write = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      lat_mode = 1;
      fork
         req_i(1'b0, 28'h44, '0, rd, ex, done);
         req_d(1'b0, 28'h48, '0, rd2, ex2, done);
         begin
            @(negedge clk); @(negedge clk);
            assertions++;
            if (mem_read !== 1'b1 || mem_addr !== 28'h44) begin
               failures++; $display("FAIL rstmid_tie: read=%b addr=%h, required I read of 44", mem_read, mem_addr);
            end
         end
      join
      assertions++;
      if (rd !== ex || rd2 !== ex2) begin
         failures++; $display("FAIL rstmid_rdata: got %h/%h, required %h/%h", rd, rd2, ex, ex2);
      end
   endtask

   task automatic test_random();
      lat_mode = -1;
      rdy_log.delete();
      fork
         begin
            logic [DATA_W-1:0] rd, ex;
            int done;
            logic wr;
            for (int k = 0; k < 10; k++) begin
               repeat ($urandom_range(0, 2)) sync();
               wr = 1'($urandom_range(0, 1));
               req_i(wr, ADDR_W'($urandom_range(0, 63)), {$urandom, $urandom, $urandom, $urandom}, rd, ex, done);
               if (!wr) begin
                  assertions++;
                  if (rd !== ex) begin
                     failures++; $display("FAIL rand_i_rdata: got %h, required %h", rd, ex);
                  end
               end
            end
         end
         begin
            logic [DATA_W-1:0] rd, ex;
            int done;
            logic wr;
            for (int k = 0; k < 10; k++) begin
               repeat ($urandom_range(0, 2)) sync();
               wr = 1'($urandom_range(0, 1));
               req_d(wr, ADDR_W'($urandom_range(0, 63)), {$urandom, $urandom, $urandom, $urandom}, rd, ex, done);
               if (!wr) begin
                  assertions++;
                  if (rd !== ex) begin
                     failures++; $display("FAIL rand_d_rdata: got %h, required %h", rd, ex);
                  end
               end
            end
         end
      join
      assertions++;
      if (rdy_log.size() != 20) begin
         failures++; $display("FAIL rand_ready_count: got %0d pulses, required 20", rdy_log.size());
      end
   endtask

   task automatic test_perf();
      logic [DATA_W-1:0] rd, ex;
      int done;
`ifdef MEM_ARB_PERF_EN
      apply_reset();
      lat_mode = 1;
      req_i(1'b0, 28'h01, '0, rd, ex, done);
      req_d(1'b0, 28'h02, '0, rd, ex, done);
      req_i(1'b0, 28'h03, '0, rd, ex, done);
      fork
         req_i(1'b0, 28'h04, '0, rd, ex, done);
         req_d(1'b0, 28'h05, '0, rd, ex, done);
      join
      @(negedge clk);
      assertions++;
      if (perf_i_grants !== 32'd3 || perf_d_grants !== 32'd2) begin
         failures++; $display("FAIL perf_grants: i=%0d d=%0d, required 3 / 2", perf_i_grants, perf_d_grants);
      end
      // Loser waits through the tie cycle plus the winner's lat+1 grant cycles
      assertions++;
      if (perf_wait !== 32'(lat_mode + 2)) begin
         failures++; $display("FAIL perf_wait: got %0d, required %0d", perf_wait, lat_mode + 2);
      end
      sync();
      fork
         req_i(1'b0, 28'h06, '0, rd, ex, done);
         req_d(1'b0, 28'h07, '0, rd, ex, done);
         begin
            @(negedge clk); @(negedge clk);
            force dut.u_perf.wait_cnt = 32'hFFFF_FFFF;
            #1 release dut.u_perf.wait_cnt;
            @(negedge clk);
            assertions++;
            if (perf_wait !== 32'hFFFF_FFFF) begin
               failures++; $display("FAIL perf_saturate: got %h, required FFFFFFFF", perf_wait);
            end
         end
      join
`else
      lat_mode = 1;
      fork
         req_i(1'b0, 28'h01, '0, rd, ex, done);
         req_d(1'b0, 28'h02, '0, rd, ex, done);
      join
      assertions++;
      if (perf_i_grants !== 0 || perf_d_grants !== 0 || perf_wait !== 0) begin
         failures++; $display("FAIL perf_tied_off: %0d %0d %0d, required 0 0 0", perf_i_grants, perf_d_grants, perf_wait);
      end
`endif
   endtask

   initial begin
      for (int a = 0; a < 256; a++) begin
         mem_arr[a] = DATA_W'(a);
         shadow[a]  = DATA_W'(a);
      end
      i_read = 0; i_write = 0; i_addr = '0; i_wdata = '0;
      d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
      rst_n = 1'b0;
      test_reset();
      test_solo_read();
      test_tie();
      test_stream();
      test_reset_mid();
      test_random();
      test_perf();
      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
